// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU op scheduler.
// Widths, FSM state encoding and the response bundle.
package alu_sched_pkg;

  localparam int OP_W     = 4;
  localparam int DATA_W   = 64;
  localparam int FLAG_W   = 4;
  localparam int ID_MAX_W = 2;
  localparam int ERR_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_e;

  // id is sized for up to 4 requesters; the top truncates it.
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [DATA_W-1:0]   result;
    logic [3*FLAG_W-1:0] flags;
    logic                illegal;
  } rsp_t;

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request, ALU and response signals of the scheduler.
// slave: scheduler side; master: requesters/ALU/consumer side.
interface alu_op_scheduler_if
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) ();

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [OP_W*NUM_REQ-1:0]   req_op_i;
  logic [DATA_W*NUM_REQ-1:0] req_a_i;
  logic [DATA_W*NUM_REQ-1:0] req_b_i;
  logic [OP_W-1:0]           alu_op_o;
  logic [DATA_W-1:0]         alu_a_o;
  logic [DATA_W-1:0]         alu_b_o;
  logic [DATA_W-1:0]         alu_result_i;
  logic [FLAG_W-1:0]         alu_exc_i;
  logic [FLAG_W-1:0]         alu_ovf_i;
  logic [FLAG_W-1:0]         alu_unf_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [ID_W-1:0]           rsp_id_o;
  logic [DATA_W-1:0]         rsp_result_o;
  logic [3*FLAG_W-1:0]       rsp_flags_o;
  logic                      rsp_illegal_o;
  logic                      busy_o;
  logic [ERR_W-1:0]          err_cnt_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i,
    input  alu_result_i, alu_exc_i, alu_ovf_i, alu_unf_i,
    input  rsp_ready_i,
    output req_ready_o, alu_op_o, alu_a_o, alu_b_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o,
    output rsp_flags_o, rsp_illegal_o, busy_o, err_cnt_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i,
    output alu_result_i, alu_exc_i, alu_ovf_i, alu_unf_i,
    output rsp_ready_i,
    input  req_ready_o, alu_op_o, alu_a_o, alu_b_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o,
    input  rsp_flags_o, rsp_illegal_o, busy_o, err_cnt_o
  );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority after last winner.
// Ports: clk_i, rst_ni (sync, active-low), req_i, adv_i, gnt_o.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_q) + i) % NUM_REQ] = 1'b1;
        ptr_d = PW'(((int'(ptr_q) + i) % NUM_REQ + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Sequences requests onto one shared ALU, one op in flight.
// Ports: wb_clk_i, wb_rst_ni (sync, active-low), bus (slave).
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int ALU_LAT = 2,
  parameter int NUM_OPS = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  alu_op_scheduler_if.slave bus
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [ID_MAX_W-1:0] id_q, id_d;
  rsp_t                rsp_q, rsp_d;
  logic [ERR_W-1:0]    err_q, err_d;

  logic                idle;
  logic                hs;
  logic                flagged;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [ID_MAX_W-1:0] sel_id;

  assign idle    = (state_q == S_IDLE);
  assign req     = bus.req_valid_i & {NUM_REQ{idle}};
  assign hs      = |gnt;
  assign flagged = (|rsp_q.flags) | rsp_q.illegal;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .req_i  (req),
    .adv_i  (hs),
    .gnt_o  (gnt)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_op = bus.req_op_i[OP_W*k +: OP_W];
        sel_a  = bus.req_a_i[DATA_W*k +: DATA_W];
        sel_b  = bus.req_b_i[DATA_W*k +: DATA_W];
        sel_id = ID_MAX_W'(k);
      end
    end
  end

  // ALU regs load at the handshake so inputs change at T+1;
  // ISSUE counts as the first settle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (int'(sel_op) >= NUM_OPS) begin
            rsp_d   = '{id: sel_id, result: '0,
                        flags: '0, illegal: 1'b1};
            state_d = S_RESP;
          end else begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            id_d    = sel_id;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'd1;
        state_d = (ALU_LAT == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ALU_LAT - 1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_d   = '{id: id_q, result: bus.alu_result_i,
                    flags: {bus.alu_exc_i, bus.alu_ovf_i,
                            bus.alu_unf_i},
                    illegal: 1'b0};
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
          if (flagged && (err_q != '1)) err_d = err_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      rsp_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o   = gnt;
  assign bus.alu_op_o      = op_q;
  assign bus.alu_a_o       = a_q;
  assign bus.alu_b_o       = b_q;
  assign bus.rsp_valid_o   = (state_q == S_RESP);
  assign bus.rsp_id_o      = ID_W'(rsp_q.id);
  assign bus.rsp_result_o  = rsp_q.result;
  assign bus.rsp_flags_o   = rsp_q.flags;
  assign bus.rsp_illegal_o = rsp_q.illegal;
  assign bus.busy_o        = !idle;
  assign bus.err_cnt_o     = err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler with a delayed ALU model.
// Drives at posedge+1, observes at negedge.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int ALU_LAT = 2;
  localparam int NUM_OPS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_op_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .ALU_LAT (ALU_LAT),
    .NUM_OPS (NUM_OPS)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [159:0] obs,
                     logic [159:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] alu_f(logic [3:0] op,
                                        logic [63:0] a,
                                        logic [63:0] b);
    if (op == 4'd2)
      return $realtobits($bitstoreal(a) + $bitstoreal(b));
    return a ^ {b[59:0], op};
  endfunction

  function automatic logic [11:0] flg_f(logic [3:0] op);
    logic [3:0] e, o, u;
    e = (op == 4'd3) ? 4'b0010 : 4'b0000;
    o = (op == 4'd4) ? 4'b0001 : 4'b0000;
    u = (op == 4'd8) ? 4'b0100 : 4'b0000;
    return {e, o, u};
  endfunction

  // ALU model: outputs valid ALU_LAT cycles after inputs change.
  logic [75:0] pipe [ALU_LAT];
  always @(posedge clk) begin
    pipe[0] <= {alu_f(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o),
                flg_f(bus.alu_op_o)};
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.alu_result_i = pipe[ALU_LAT-1][75:12];
  assign bus.alu_exc_i    = pipe[ALU_LAT-1][11:8];
  assign bus.alu_ovf_i    = pipe[ALU_LAT-1][7:4];
  assign bus.alu_unf_i    = pipe[ALU_LAT-1][3:0];

  rsp_t            sbq[$];
  int              gq[$];
  int              cyc = 0;
  int              hs_cyc = 0;
  bit              hs_ill = 0;
  bit              pend = 0;
  bit              pv = 0;
  logic [131:0]    pend_in;
  rsp_t            prev;
  logic [15:0]     err_exp = '0;

  always @(negedge clk) begin
    rsp_t cur, e;
    logic [3:0] op;
    logic [63:0] a, b;
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      err_exp = '0;
      pv = 0;
      pend = 0;
    end else begin
      chk("gnt_onehot",
          160'($countones(bus.req_ready_o) <= 1), 160'd1);
      chk("err_cnt", 160'(bus.err_cnt_o), 160'(err_exp));
      if (pend && cyc == hs_cyc + 1) begin
        chk("alu_in",
            160'({bus.alu_op_o, bus.alu_a_o, bus.alu_b_o}),
            160'(pend_in));
        pend = 0;
      end
      if (bus.rsp_valid_o) begin
        cur = '{id: 2'(bus.rsp_id_o),
                result: bus.rsp_result_o,
                flags: bus.rsp_flags_o,
                illegal: bus.rsp_illegal_o};
        if (!pv)
          chk("rsp_lat", 160'(cyc - hs_cyc),
              160'(hs_ill ? 1 : ALU_LAT + 2));
        else
          chk("rsp_stable", 160'(cur), 160'(prev));
        prev = cur;
        if (bus.rsp_ready_i) begin
          if (sbq.size() == 0) begin
            chk("sb_empty", 160'd0, 160'd1);
          end else begin
            e = sbq.pop_front();
            chk("rsp", 160'(cur), 160'(e));
            if ((|e.flags || e.illegal) && err_exp != 16'hFFFF)
              err_exp = err_exp + 16'd1;
          end
          pv = 0;
        end else begin
          pv = 1;
        end
      end else begin
        pv = 0;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
          op = bus.req_op_i[4*k +: 4];
          a  = bus.req_a_i[64*k +: 64];
          b  = bus.req_b_i[64*k +: 64];
          gq.push_back(k);
          hs_cyc = cyc;
          hs_ill = (int'(op) >= NUM_OPS);
          if (hs_ill)
            sbq.push_back('{id: 2'(k), result: '0,
                            flags: '0, illegal: 1'b1});
          else
            sbq.push_back('{id: 2'(k), result: alu_f(op, a, b),
                            flags: flg_f(op), illegal: 1'b0});
          pend = !hs_ill;
          pend_in = {op, a, b};
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [3:0] op, logic [63:0] a,
                      logic [63:0] b, bit keep);
    int n = 0;
    bus.req_valid_i[k]        = 1'b1;
    bus.req_op_i[4*k +: 4]    = op;
    bus.req_a_i[64*k +: 64]   = a;
    bus.req_b_i[64*k +: 64]   = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready_o[k] && n < 200);
    if (n >= 200) chk("req_timeout", 160'd0, 160'd1);
    @(posedge clk);
    #1;
    if (!keep || n >= 200) bus.req_valid_i[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy_o && n < 200);
    if (n >= 200) chk("idle_timeout", 160'd0, 160'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"},
        160'({bus.req_ready_o, bus.rsp_valid_o, bus.busy_o,
              bus.err_cnt_o, bus.alu_op_o, bus.alu_a_o,
              bus.alu_b_o}), 160'd0);
    chk({tag, "_rsp"},
        160'({bus.rsp_id_o, bus.rsp_result_o, bus.rsp_flags_o,
              bus.rsp_illegal_o}), 160'd0);
  endtask

  initial begin
    logic [3:0] saved_op;
    int n;
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(1);

    fork
      begin
        send(0, 4'd1, 64'h1111, 64'h2222, 1'b1);
        send(0, 4'd5, 64'hABCD_0000, 64'h77, 1'b0);
      end
      begin
        send(1, 4'd6, 64'h5555_AAAA, 64'h9, 1'b1);
        send(1, 4'd7, 64'hDEAD_BEEF, 64'h123, 1'b0);
      end
    join
    wait_idle();
    chk("rr_n", 160'(gq.size()), 160'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("rr_gnt", 160'(gq[i]), 160'(i % 2));

    send(0, 4'd2, 64'h3FF0_0000_0000_0000,
         64'h4000_0000_0000_0000, 1'b0);
    wait_idle();
    chk("add_err", 160'(bus.err_cnt_o), 160'd0);

    saved_op = bus.alu_op_o;
    send(0, 4'hF, 64'h1, 64'h2, 1'b0);
    wait_idle();
    chk("ill_aluop", 160'(bus.alu_op_o), 160'(saved_op));
    chk("ill_err", 160'(bus.err_cnt_o), 160'd1);

    bus.rsp_ready_i = 1'b0;
    send(1, 4'd3, 64'h4242, 64'h99, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid_o && n < 50);
    if (n >= 50) chk("stall_timeout", 160'd0, 160'd1);
    tick(5);
    chk("stall_err_hold", 160'(bus.err_cnt_o), 160'd1);
    bus.rsp_ready_i = 1'b1;
    wait_idle();
    chk("stall_err_inc", 160'(bus.err_cnt_o), 160'd2);

    force dut.err_q = 16'hFFFF;
    err_exp = 16'hFFFF;
    @(negedge clk);
    release dut.err_q;
    tick(1);
    send(0, 4'd4, 64'h10, 64'h20, 1'b0);
    wait_idle();
    chk("err_sat", 160'(bus.err_cnt_o), 160'hFFFF);

    send(0, 4'd5, 64'h33, 64'h44, 1'b0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk_zero("mid_rst");
    rst_n = 1'b1;
    gq.delete();
    send(1, 4'd6, 64'h8888, 64'h1, 1'b0);
    wait_idle();
    chk("post_rst_n", 160'(gq.size()), 160'd1);
    if (gq.size() > 0)
      chk("post_rst_gnt", 160'(gq[0]), 160'd1);
    chk("post_rst_sb", 160'(sbq.size()), 160'd0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
